load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 25 ++
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit (master) and the data memory (slave).
// One request is outstanding at a time; the slave completes it with a single bus_ready pulse.
interface load_store_unit_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned BE_W = WIDTH / 8;

  logic             bus_req;
  logic             bus_we;
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic [BE_W-1:0]  bus_be;
  logic             bus_ready;
  logic [WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store into a single word-aligned bus access,
// stalling the pipeline until the access completes and formatting load data.
module load_store_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [WIDTH-1:0]   addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic               stall,
  output logic [WIDTH-1:0]   read_data,
  output logic               load_valid,
  output logic               lsu_fault,
  load_store_unit_if.master  bus
);

  localparam int unsigned BE_W = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0]  bus_be_q, bus_be_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic             load_valid_q, load_valid_d;
  logic [2:0]       ld_f3_q, ld_f3_d;
  logic [1:0]       ld_off_q, ld_off_d;

  logic             any_req;
  logic             access_bad;
  logic             req_ok;
  logic [BE_W-1:0]  be_c;
  logic [WIDTH-1:0] wdata_lanes_c;
  logic [WIDTH-1:0] lane_c;
  logic [WIDTH-1:0] load_fmt_c;

  // Request legality: both strobes, reserved encodings and misalignment all fault.
  always_comb begin
    any_req    = mem_read | mem_write;
    access_bad = 1'b0;
    if (mem_read && mem_write) begin
      access_bad = 1'b1;
    end
    if (funct3 inside {3'b011, 3'b110, 3'b111}) begin
      access_bad = 1'b1;
    end
    if (mem_write && funct3[2]) begin
      access_bad = 1'b1;
    end
    if ((funct3[1:0] == 2'b01) && addr[0]) begin
      access_bad = 1'b1;
    end
    if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) begin
      access_bad = 1'b1;
    end
    lsu_fault = (state_q == IDLE) && any_req && access_bad;
    req_ok    = (state_q == IDLE) && (mem_read ^ mem_write) && !access_bad;
    stall     = req_ok || (state_q == ACCESS);
  end

  // Byte enables and lane-replicated store data for the requested access size.
  always_comb begin
    be_c          = BE_W'(4'b1111);
    wdata_lanes_c = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        be_c          = BE_W'(4'b0001 << addr[1:0]);
        wdata_lanes_c = WIDTH'({4{wdata[7:0]}});
      end
      2'b01: begin
        be_c          = BE_W'(4'b0011 << {addr[1], 1'b0});
        wdata_lanes_c = WIDTH'({2{wdata[15:0]}});
      end
      default: begin
        be_c          = BE_W'(4'b1111);
        wdata_lanes_c = wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane_c = bus.bus_rdata >> {ld_off_q, 3'b000};
    unique case (ld_f3_q)
      3'b000:  load_fmt_c = {{(WIDTH-8){lane_c[7]}}, lane_c[7:0]};
      3'b001:  load_fmt_c = {{(WIDTH-16){lane_c[15]}}, lane_c[15:0]};
      3'b100:  load_fmt_c = {{(WIDTH-8){1'b0}}, lane_c[7:0]};
      3'b101:  load_fmt_c = {{(WIDTH-16){1'b0}}, lane_c[15:0]};
      default: load_fmt_c = lane_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    read_data_d  = read_data_q;
    load_valid_d = 1'b0;
    ld_f3_d      = ld_f3_q;
    ld_off_d     = ld_off_q;

    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d     = ACCESS;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[WIDTH-1:2], 2'b00};
          bus_wdata_d = mem_write ? wdata_lanes_c : '0;
          bus_be_d    = be_c;
          ld_f3_d     = funct3;
          ld_off_d    = addr[1:0];
        end
      end
      ACCESS: begin
        if (bus.bus_ready) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_be_d  = '0;
          if (!bus_we_q) begin
            read_data_d  = load_fmt_c;
            load_valid_d = 1'b1;
          end
        end
      end
      // The core still holds its request here; returning straight to IDLE
      // gives it the cycle it needs to advance past the instruction.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      read_data_q  <= '0;
      load_valid_q <= 1'b0;
      ld_f3_q      <= 3'b000;
      ld_off_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      read_data_q  <= read_data_d;
      load_valid_q <= load_valid_d;
      ld_f3_q      <= ld_f3_d;
      ld_off_q     <= ld_off_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;
  assign read_data     = read_data_q;
  assign load_valid    = load_valid_q;

endmodule
